// File: rtl/serial_pattern_pkg.sv
// Shared types and default parameters for the serial pattern source.
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_WIDTH           = 8;
    localparam int DEF_BIT_CYCLES      = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    // Counter width for a count range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_pattern_source_debouncer.sv
// Two-flop synchronizer plus debouncer for the start pushbutton; emits the
// debounced level and a one-cycle pulse on each debounced rising edge.
module button_debouncer
    import serial_pattern_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the current level.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/serial_pattern_source.sv
// Shifts a switch-selected pattern out MSB first on a debounced button press.
// Define SERIAL_PATTERN_LOOP_EN to repeat the pattern until the next press.
module serial_pattern_source
    import serial_pattern_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int BIT_CYCLES      = DEF_BIT_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     btn_start,
    input  logic [WIDTH-1:0]         sw_pattern,
    output logic                     sig_out,
    output logic                     bit_strobe,
    output logic [$clog2(WIDTH)-1:0] bit_index,
    output logic                     busy,
    output logic                     done
);

    localparam int               IDX_W      = $clog2(WIDTH);
    localparam int               TW         = cnt_width(BIT_CYCLES);
    localparam logic [TW-1:0]    TIMER_LOAD = TW'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WIDTH - 1);

    logic start_evt;
    logic btn_level;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .rst_n  (rst),
        .btn_i  (btn_start),
        .level_o(btn_level),
        .rise_o (start_evt)
    );

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sig_q, sig_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_PATTERN_LOOP_EN
    logic               stop_q, stop_d;
`endif

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        sig_d    = sig_q;
        strobe_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SERIAL_PATTERN_LOOP_EN
        stop_d   = stop_q;
`endif
        case (state_q)
            IDLE: begin
                sig_d  = 1'b1;
                busy_d = 1'b0;
                idx_d  = '0;
`ifdef SERIAL_PATTERN_LOOP_EN
                stop_d = 1'b0;
`endif
                if (start_evt && ena) begin
                    state_d  = SHIFT;
                    sr_d     = sw_pattern;
                    timer_d  = TIMER_LOAD;
                    sig_d    = sw_pattern[WIDTH-1];
                    strobe_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            SHIFT: begin
                if (ena) begin
`ifdef SERIAL_PATTERN_LOOP_EN
                    if (start_evt) stop_d = 1'b1;
`endif
                    if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
`ifdef SERIAL_PATTERN_LOOP_EN
                    end else if (!stop_q && idx_q == LAST_IDX) begin
                        // Wrap straight into the next repeat with no idle bit.
                        sr_d     = sw_pattern;
                        timer_d  = TIMER_LOAD;
                        idx_d    = '0;
                        sig_d    = sw_pattern[WIDTH-1];
                        strobe_d = 1'b1;
                        done_d   = 1'b1;
                    end else if (stop_q || idx_q == LAST_IDX) begin
`else
                    end else if (idx_q == LAST_IDX) begin
`endif
                        state_d = DONE;
                        sr_d    = '1;
                        timer_d = '0;
                        idx_d   = '0;
                        sig_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        sr_d     = {sr_q[WIDTH-2:0], 1'b1};
                        timer_d  = TIMER_LOAD;
                        idx_d    = idx_q + 1'b1;
                        sig_d    = sr_q[WIDTH-2];
                        strobe_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                sig_d   = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
`ifdef SERIAL_PATTERN_LOOP_EN
                stop_d  = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
                sig_d   = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sr_q     <= '1;
            timer_q  <= '0;
            idx_q    <= '0;
            sig_q    <= 1'b1;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_PATTERN_LOOP_EN
            stop_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            sig_q    <= sig_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_PATTERN_LOOP_EN
            stop_q   <= stop_d;
`endif
        end
    end

    assign sig_out    = sig_q;
    assign bit_strobe = strobe_q;
    assign bit_index  = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Directed bench for serial_pattern_source at default parameters; the loop
// scenario runs when SERIAL_PATTERN_LOOP_EN is defined.
module tb_serial_pattern_source;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       btn_start;
    logic [7:0] sw_pattern;
    logic       sig_out;
    logic       bit_strobe;
    logic [2:0] bit_index;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;
    int btn_hold = 0;

    int busy_cyc = 0;
    int done_cnt = 0;
    int strobe_cnt = 0;
    int idx3_cyc = 0;
    int frozen_strobe = 0;

    serial_pattern_source dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .btn_start (btn_start),
        .sw_pattern(sw_pattern),
        .sig_out   (sig_out),
        .bit_strobe(bit_strobe),
        .bit_index (bit_index),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (bit_strobe) strobe_cnt++;
        if (busy && bit_index == 3'd3) idx3_cyc++;
        if (bit_strobe && !ena) frozen_strobe++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (btn_hold > 0) begin
            btn_hold--;
            if (btn_hold == 0) btn_start = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int hold);
        btn_start = 1'b1;
        btn_hold  = hold;
    endtask

    function automatic logic cond(input int what, input int idx);
        case (what)
            0:       return bit_strobe;
            1:       return done;
            2:       return !busy;
            3:       return bit_strobe && (int'(bit_index) == idx);
            default: return 1'b1;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int what, input int idx,
                            input int limit, output int n);
        n = 0;
        while (!cond(what, idx) && n < limit) begin
            tick();
            n++;
        end
        if (!cond(what, idx)) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int n;
        int s_busy, s_done, s_strobe, s_idx3, s_frozen;

        pat        = 8'b0101_0011;
        rst        = 1'b0;
        ena        = 1'b1;
        btn_start  = 1'b0;
        sw_pattern = 8'h00;
        ticks(3);
        chk("rst_sig_out", 32'(sig_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bit_index", 32'(bit_index), 32'd0);
        chk("rst_strobe", 32'(bit_strobe), 32'd0);
        rst = 1'b1;
        ticks(5);

`ifdef SERIAL_PATTERN_LOOP_EN
        sw_pattern = 8'h0F;
        press(20);
        wait_for("loop_start", 0, 0, 60, n);
        chk("loop_start_latency", n, 19);
        chk("loop_first_bit", 32'(sig_out), 32'd0);
        wait_for("loop_done1", 1, 0, 60, n);
        chk("loop_period1", n, 32);
        chk("loop_wrap_busy", 32'(busy), 32'd1);
        chk("loop_wrap_idx", 32'(bit_index), 32'd0);
        chk("loop_wrap_strobe", 32'(bit_strobe), 32'd1);
        chk("loop_wrap_sig", 32'(sig_out), 32'd0);
        tick();
        wait_for("loop_done2", 1, 0, 60, n);
        chk("loop_period2", n + 1, 32);
        press(20);
        wait_for("loop_stop", 2, 0, 120, n);
        chk("loop_stop_bound", 32'(n <= 24), 32'd1);
        chk("loop_stop_done", 32'(done), 32'd1);
        chk("loop_stop_sig", 32'(sig_out), 32'd1);
        s_busy = busy_cyc;
        s_done = done_cnt;
        ticks(70);
        chk("loop_after_busy", busy_cyc - s_busy, 0);
        chk("loop_after_done", done_cnt - s_done, 0);
        chk("loop_after_idx", 32'(bit_index), 32'd0);
`else
        // Basic run, pattern switches changed after capture.
        sw_pattern = pat;
        press(20);
        wait_for("run_start", 0, 0, 60, n);
        chk("run_start_latency", n, 19);
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < 4; c++) begin
                if (b == 0 && c == 1) sw_pattern = 8'hAA;
                chk("run_sig", 32'(sig_out), 32'(pat[7-b]));
                chk("run_idx", 32'(bit_index), 32'(b));
                chk("run_strobe", 32'(bit_strobe), 32'(c == 0));
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_done", 32'(done), 32'd0);
                tick();
            end
        end
        chk("run_end_done", 32'(done), 32'd1);
        chk("run_end_sig", 32'(sig_out), 32'd1);
        chk("run_end_busy", 32'(busy), 32'd0);
        tick();
        chk("run_idle_done", 32'(done), 32'd0);
        chk("run_idle_sig", 32'(sig_out), 32'd1);
        chk("run_idle_idx", 32'(bit_index), 32'd0);
        ticks(40);

        // Bouncing button, then stable high.
        sw_pattern = pat;
        s_busy = busy_cyc;
        for (int i = 0; i < 40; i++) begin
            btn_start = ((i / 3) % 2 == 0);
            tick();
        end
        chk("bounce_no_start", busy_cyc - s_busy, 0);
        btn_start = 1'b1;
        wait_for("bounce_start", 0, 0, 60, n);
        chk("bounce_latency", n, 19);
        wait_for("bounce_done", 1, 0, 60, n);
        tick();
        s_busy = busy_cyc;
        ticks(30);
        chk("bounce_single_start", busy_cyc - s_busy, 0);
        btn_start = 1'b0;
        ticks(40);

        // Start event while disabled is dropped.
        ena = 1'b0;
        press(25);
        s_busy = busy_cyc;
        ticks(30);
        ena = 1'b1;
        ticks(10);
        chk("ena_drop_busy", busy_cyc - s_busy, 0);
        chk("ena_drop_sig", 32'(sig_out), 32'd1);
        ticks(20);

        // Freeze for 10 cycles during bit 3.
        s_busy = busy_cyc; s_done = done_cnt; s_strobe = strobe_cnt;
        s_idx3 = idx3_cyc; s_frozen = frozen_strobe;
        press(20);
        wait_for("frz_bit3", 3, 3, 80, n);
        tick();
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("frz_sig", 32'(sig_out), 32'(pat[4]));
            chk("frz_idx", 32'(bit_index), 32'd3);
            chk("frz_strobe", 32'(bit_strobe), 32'd0);
        end
        ena = 1'b1;
        wait_for("frz_done", 1, 0, 60, n);
        tick();
        chk("frz_total_busy", busy_cyc - s_busy, 42);
        chk("frz_bit3_cycles", idx3_cyc - s_idx3, 14);
        chk("frz_strobes", strobe_cnt - s_strobe, 8);
        chk("frz_dones", done_cnt - s_done, 1);
        chk("frz_no_strobe", frozen_strobe - s_frozen, 0);
        ticks(40);

        // Reset during bit 5 aborts the run.
        press(20);
        wait_for("rst_bit5", 3, 5, 80, n);
        tick();
        s_done = done_cnt;
        rst = 1'b0;
        #1;
        chk("abort_sig", 32'(sig_out), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_idx", 32'(bit_index), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        ticks(2);
        rst = 1'b1;
        s_busy = busy_cyc;
        ticks(30);
        chk("abort_no_restart", busy_cyc - s_busy, 0);
        chk("abort_no_done", done_cnt - s_done, 0);
        press(20);
        wait_for("rerun_start", 0, 0, 60, n);
        chk("rerun_latency", n, 19);
        chk("rerun_idx", 32'(bit_index), 32'd0);
        chk("rerun_sig", 32'(sig_out), 32'(pat[7]));
        wait_for("rerun_done", 1, 0, 60, n);
        chk("rerun_len", n, 32);
        ticks(5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
